// File: rtl/fpa_pkg.sv
`default_nettype none
// ============================================================================
// fpa_pkg: shared types and constants for the fpa_add_unit slice.  Rev 1.0
// ============================================================================
package fpa_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_EXT_W  = 27;

  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_PINF = 32'h7F800000;
  localparam logic [31:0] FP_NINF = 32'hFF800000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    ALIGN  = 3'd2,
    ADD    = 3'd3,
    NORM   = 3'd4,
    ROUND  = 3'd5,
    DONE   = 3'd6
  } fpa_state_t;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    NORMAL = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } fpa_class_t;

endpackage
`default_nettype wire

// File: rtl/fpa_classify.sv
`default_nettype none
// ============================================================================
// fpa_classify: splits a single-precision operand into class/sign/exp/mantissa.  Rev 1.0
// ============================================================================
module fpa_classify
  import fpa_pkg::*;
(
  input  logic [31:0] i_op,
  output logic [1:0]  o_cls,
  output logic        o_sign,
  output logic [7:0]  o_exp,
  output logic [23:0] o_mant
);

  logic [FP_EXP_W-1:0]  w_exp;
  logic [FP_FRAC_W-1:0] w_frac;

  assign w_exp  = i_op[FP_EXP_W+FP_FRAC_W-1:FP_FRAC_W];
  assign w_frac = i_op[FP_FRAC_W-1:0];

  always_comb begin
    o_sign = i_op[31];
    o_exp  = w_exp;
    o_mant = {1'b1, w_frac};
    o_cls  = NORMAL;
    // Denormals are flushed: they classify as zero and carry no mantissa.
    if (w_exp == 8'd0) begin
      o_cls  = ZERO;
      o_mant = 24'd0;
    end else if (w_exp == 8'hFF) begin
      o_cls = (w_frac != '0) ? NAN : INF;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpa_add_unit.sv
`default_nettype none
// ============================================================================
// fpa_add_unit: multi-cycle IEEE-754 single add/sub; FPA_STATUS_EN adds o_flags.  Rev 1.0
// ============================================================================
module fpa_add_unit
  import fpa_pkg::*;
#(
  parameter int NORM_MAX = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_op_sub,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result,
  output logic        o_zero
`ifdef FPA_STATUS_EN
  ,
  output logic [3:0]  o_flags
`endif
);

  localparam int CNT_W = $clog2(NORM_MAX + 1);

  fpa_state_t          r_state;
  logic [31:0]         r_a, r_b, r_result;
  logic                r_ready, r_busy, r_done, r_zero, r_s, r_eff_sub;
  logic [9:0]          r_e;
  logic [FP_EXT_W-1:0] r_mx, r_my, r_m;
  logic [CNT_W-1:0]    r_ncnt;

  logic [1:0]  w_cls_a, w_cls_b;
  logic        w_sa, w_sb;
  logic [7:0]  w_ea, w_eb;
  logic [23:0] w_ma, w_mb;

  fpa_classify u_cls_a (.i_op(r_a), .o_cls(w_cls_a), .o_sign(w_sa), .o_exp(w_ea), .o_mant(w_ma));
  fpa_classify u_cls_b (.i_op(r_b), .o_cls(w_cls_b), .o_sign(w_sb), .o_exp(w_eb), .o_mant(w_mb));

  logic        w_invalid, w_special;
  logic [31:0] w_spec_res;

  always_comb begin
    w_invalid  = (w_cls_a == NAN) || (w_cls_b == NAN) ||
                 ((w_cls_a == INF) && (w_cls_b == INF) && (w_sa != w_sb));
    w_special  = 1'b1;
    w_spec_res = FP_QNAN;
    if (w_invalid)                              w_spec_res = FP_QNAN;
    else if (w_cls_a == INF)                    w_spec_res = r_a;
    else if (w_cls_b == INF)                    w_spec_res = r_b;
    else if (w_cls_a == ZERO && w_cls_b == ZERO) w_spec_res = {w_sa & w_sb, 31'd0};
    else if (w_cls_a == ZERO)                   w_spec_res = r_b;
    else if (w_cls_b == ZERO)                   w_spec_res = r_a;
    else                                        w_special  = 1'b0;
  end

  logic                w_a_ge, w_s_l;
  logic [7:0]          w_e_l, w_d;
  logic [23:0]         w_m_l;
  logic [FP_EXT_W-1:0] w_ext_s, w_sh, w_aligned;

  // Larger magnitude goes to the X lane; the smaller one is shifted with sticky.
  always_comb begin
    w_a_ge    = {w_ea, w_ma} >= {w_eb, w_mb};
    w_s_l     = w_a_ge ? w_sa : w_sb;
    w_e_l     = w_a_ge ? w_ea : w_eb;
    w_m_l     = w_a_ge ? w_ma : w_mb;
    w_d       = w_a_ge ? (w_ea - w_eb) : (w_eb - w_ea);
    w_ext_s   = {(w_a_ge ? w_mb : w_ma), 3'b000};
    w_sh      = w_ext_s >> w_d[4:0];
    w_aligned = {w_sh[FP_EXT_W-1:1],
                 w_sh[0] | (|(w_ext_s & ((27'd1 << w_d[4:0]) - 27'd1)))};
    if (w_d >= 8'd27) w_aligned = 27'd1;
  end

  logic [FP_EXT_W:0] w_sum;
  assign w_sum = r_eff_sub ? ({1'b0, r_mx} - {1'b0, r_my}) : ({1'b0, r_mx} + {1'b0, r_my});

  logic w_norm_max, w_unf;
  assign w_norm_max = int'(r_ncnt) >= NORM_MAX;
  assign w_unf      = (r_m != '0) && !r_m[26] && !w_norm_max && (r_e == 10'd1);

  logic        w_inc, w_ovf;
  logic [24:0] w_rnd;
  logic [22:0] w_rm;
  logic [9:0]  w_re;
  logic [31:0] w_packed;

  always_comb begin
    w_inc = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
    w_rnd = {1'b0, r_m[26:3]} + {24'd0, w_inc};
    if (w_rnd[24]) begin
      w_rm = w_rnd[23:1];
      w_re = r_e + 10'd1;
    end else begin
      w_rm = w_rnd[22:0];
      w_re = r_e;
    end
    w_ovf    = w_re >= 10'd255;
    w_packed = w_ovf ? (r_s ? FP_NINF : FP_PINF) : {r_s, w_re[7:0], w_rm};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_s       <= 1'b0;
      r_eff_sub <= 1'b0;
      r_e       <= '0;
      r_mx      <= '0;
      r_my      <= '0;
      r_m       <= '0;
      r_ncnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (i_start) begin
          r_a     <= i_a;
          r_b     <= {i_b[31] ^ i_op_sub, i_b[30:0]};
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= UNPACK;
        end
        UNPACK: if (w_special) begin
          r_result <= w_spec_res;
          r_zero   <= (w_spec_res[30:0] == 31'd0);
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= DONE;
        end else begin
          r_state <= ALIGN;
        end
        ALIGN: begin
          r_mx      <= {w_m_l, 3'b000};
          r_my      <= w_aligned;
          r_e       <= {2'b00, w_e_l};
          r_s       <= w_s_l;
          r_eff_sub <= w_sa ^ w_sb;
          r_state   <= ADD;
        end
        ADD: begin
          if (w_sum[FP_EXT_W]) begin
            r_m <= {w_sum[FP_EXT_W:2], w_sum[1] | w_sum[0]};
            r_e <= r_e + 10'd1;
          end else begin
            r_m <= w_sum[FP_EXT_W-1:0];
          end
          r_ncnt  <= '0;
          r_state <= NORM;
        end
        NORM: begin
          if (r_m == '0 || (!r_m[26] && w_norm_max)) begin
            r_m     <= '0;
            r_s     <= 1'b0;
            r_e     <= '0;
            r_state <= ROUND;
          end else if (r_m[26]) begin
            r_state <= ROUND;
          end else if (w_unf) begin
            r_m     <= '0;
            r_e     <= '0;
            r_state <= ROUND;
          end else begin
            r_m    <= r_m << 1;
            r_e    <= r_e - 10'd1;
            r_ncnt <= r_ncnt + CNT_W'(1);
          end
        end
        ROUND: begin
          r_result <= w_packed;
          r_zero   <= (w_packed[30:0] == 31'd0);
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= DONE;
        end
        DONE: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef FPA_STATUS_EN
  // Flag order {invalid, overflow, underflow, inexact}; r_wflg accumulates mid-operation.
  logic [3:0] r_wflg, r_flags;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wflg  <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        IDLE:   if (i_start) begin
          r_wflg  <= '0;
          r_flags <= '0;
        end
        UNPACK: if (w_special) r_flags <= {w_invalid, 3'b000};
        NORM:   if (w_unf) r_wflg[1] <= 1'b1;
        ROUND:  r_flags <= r_wflg | {1'b0, w_ovf, 1'b0, (|r_m[2:0]) | w_ovf | r_wflg[1]};
        default: ;
      endcase
    end
  end
  assign o_flags = r_flags;
`endif

  assign o_ready  = r_ready;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_zero   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_fpa_add_unit.sv
`default_nettype none
// ============================================================================
// tb_fpa_add_unit: directed vectors with a queue-based scoreboard for fpa_add_unit.  Rev 1.0
// ============================================================================
module tb_fpa_add_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_op_sub = 1'b0;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        o_ready, o_busy, o_done, o_zero;
  logic [31:0] o_result;
`ifdef FPA_STATUS_EN
  logic [3:0]  o_flags;
`endif

  fpa_add_unit #(.NORM_MAX(26)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (i_start),
    .i_op_sub (i_op_sub),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_ready  (o_ready),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result),
    .o_zero   (o_zero)
`ifdef FPA_STATUS_EN
    ,
    .o_flags  (o_flags)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          lat;
    logic [3:0]  flg;
    int          acc;
    int          id;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && o_done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        m_e = q.pop_front();
        chk($sformatf("v%0d.result", m_e.id), o_result, m_e.res);
        chk($sformatf("v%0d.zero", m_e.id), {31'd0, o_zero}, {31'd0, m_e.z});
        chk($sformatf("v%0d.latency", m_e.id), 32'(cyc - m_e.acc + 1), 32'(m_e.lat));
        chk($sformatf("v%0d.ready_busy", m_e.id), {30'd0, o_ready, o_busy}, 32'd0);
`ifdef FPA_STATUS_EN
        chk($sformatf("v%0d.flags", m_e.id), {28'd0, o_flags}, {28'd0, m_e.flg});
`endif
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [31:0] res, input logic z, input int lat,
                       input logic [3:0] flg);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    i_a      = a;
    i_b      = b;
    i_op_sub = sub;
    i_start  = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    vid++;
    e.res = res; e.z = z; e.lat = lat; e.flg = flg; e.acc = cyc; e.id = vid;
    q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ready"}, {31'd0, o_ready}, 32'd1);
    chk({tag, ".busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, ".done"}, {31'd0, o_done}, 32'd0);
    chk({tag, ".result"}, o_result, 32'd0);
    chk({tag, ".zero"}, {31'd0, o_zero}, 32'd1);
`ifdef FPA_STATUS_EN
    chk({tag, ".flags"}, {28'd0, o_flags}, 32'd0);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset");

    // 1.0 + 2.0, with busy observed across cycles 1..5
    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 6, 4'b0000);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("busy_c%0d", i), {31'd0, o_busy}, 32'd1);
    end
    drain();

    issue(32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 1'b0, 29, 4'b0000);
    issue(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b1, 6,  4'b0000);
    issue(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 6,  4'b0001);
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 6,  4'b0101);
    issue(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 2,  4'b1000);
    issue(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 2,  4'b1000);
    issue(32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 2,  4'b0000);
    issue(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 6,  4'b0001);
    issue(32'h3F800000, 32'h0D800000, 1'b1, 32'h3F800000, 1'b0, 7,  4'b0001);
    issue(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b1, 6,  4'b0011);
    issue(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b1, 2,  4'b0000);
    issue(32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 1'b0, 2,  4'b0000);
    issue(32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 1'b0, 2,  4'b0000);
    drain();

    // start pulsed while busy must be dropped; result holds the previous value
    issue(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 7, 4'b0000);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      i_a     = 32'h7FC00000;
      i_b     = 32'h3F800000;
      i_start = 1'b1;
      chk($sformatf("held_result_c%0d", i), o_result, 32'h7F800000);
    end
    @(negedge clk);
    i_start = 1'b0;
    drain();

    // reset in the middle of a long normalisation
    issue(32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 1'b0, 29, 4'b0000);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("midop_reset");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 6, 4'b0000);
    drain();
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
